// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer
//   Captures committed instructions for tracing. Each cycle, up to NR_COMMIT_PORTS commits are
//   classified by their major opcode and written, in ascending port order, into a DEPTH-entry
//   FIFO. The FIFO drains one record per cycle to a valid/ready trace consumer. Alongside the
//   FIFO the block keeps a saturating commit counter per class and a saturating counter of
//   commits lost because the FIFO had no room. The block only observes the commit stage and
//   never stalls it.
//
// Ports
//   clk_i           clock
//   rst_ni          asynchronous reset, active low
//   flush_i         empty the FIFO; counters are kept
//   clear_cnt_i     zero the drop counter and all class counters
//   commit_valid_i  per-port commit strobe
//   commit_instr_i  per-port 32-bit instruction, port p at [32p+:32]
//   commit_pc_i     per-port PC, port p at [XLEN*p+:XLEN]
//   trace_valid_o   head record valid
//   trace_ready_i   consumer accepts the head record
//   trace_instr_o   head instruction
//   trace_pc_o      head PC
//   trace_class_o   head class code
//   trace_port_o    commit port the head record came from
//   full_o          FIFO holds DEPTH records
//   empty_o         FIFO holds no records
//   drop_cnt_o      commits lost to overflow
//   class_cnt_o     per-class commit counts, class c at [CNT_WIDTH*c+:CNT_WIDTH]
module instr_trace_buffer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned XLEN            = 64,
    parameter int unsigned CNT_WIDTH       = 32,
    localparam int unsigned PORT_W         = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  logic                              clear_cnt_i,
    input  logic [NR_COMMIT_PORTS-1:0]        commit_valid_i,
    input  logic [32*NR_COMMIT_PORTS-1:0]     commit_instr_i,
    input  logic [XLEN*NR_COMMIT_PORTS-1:0]   commit_pc_i,
    output logic                              trace_valid_o,
    input  logic                              trace_ready_i,
    output logic [31:0]                       trace_instr_o,
    output logic [XLEN-1:0]                   trace_pc_o,
    output logic [2:0]                        trace_class_o,
    output logic [PORT_W-1:0]                 trace_port_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [CNT_WIDTH-1:0]              drop_cnt_o,
    output logic [8*CNT_WIDTH-1:0]            class_cnt_o
);

    localparam int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned COUNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned NR_CLASSES = 8;

    localparam logic [2:0] CLS_OTHER  = 3'd0;
    localparam logic [2:0] CLS_CTRL   = 3'd1;
    localparam logic [2:0] CLS_LOAD   = 3'd2;
    localparam logic [2:0] CLS_STORE  = 3'd3;
    localparam logic [2:0] CLS_SYSTEM = 3'd4;
    localparam logic [2:0] CLS_FP     = 3'd5;
    localparam logic [2:0] CLS_SUBFP  = 3'd6;
    localparam logic [2:0] CLS_AMO    = 3'd7;

    typedef struct packed {
        logic [31:0]       instr;
        logic [XLEN-1:0]   pc;
        logic [2:0]        cls;
        logic [PORT_W-1:0] port;
    } trace_rec_t;

    // Decode on instr[6:2]; anything not ending in 2'b11 is a compressed encoding -> OTHER.
    function automatic logic [2:0] classify(input logic [31:0] instr);
        logic [2:0] cls;
        cls = CLS_OTHER;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:2])
                5'b11000, 5'b11011, 5'b11001:                   cls = CLS_CTRL;
                5'b00000, 5'b00001:                             cls = CLS_LOAD;
                5'b01000, 5'b01001:                             cls = CLS_STORE;
                5'b11100:                                       cls = CLS_SYSTEM;
                5'b10100, 5'b10000, 5'b10001, 5'b10010, 5'b10011: cls = CLS_FP;
                5'b01010:                                       cls = CLS_SUBFP;
                5'b01011:                                       cls = CLS_AMO;
                default:                                        cls = CLS_OTHER;
            endcase
        end
        return cls;
    endfunction

    // Pointer advance modulo DEPTH, valid for any DEPTH including 1.
    function automatic logic [ADDR_W-1:0] ptr_add(input logic [ADDR_W-1:0] ptr,
                                                  input int unsigned inc);
        int unsigned sum;
        sum = (int'(ptr) + inc) % DEPTH;
        return sum[ADDR_W-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                     input int unsigned inc);
        logic [CNT_WIDTH:0] sum;
        sum = {1'b0, cnt} + (CNT_WIDTH+1)'(inc);
        return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    endfunction

    // State
    trace_rec_t           mem_q [DEPTH];
    logic [ADDR_W-1:0]    rd_ptr_q;
    logic [ADDR_W-1:0]    wr_ptr_q;
    logic [COUNT_W-1:0]   count_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;
    logic [CNT_WIDTH-1:0] class_cnt_q [NR_CLASSES];

    // Next-state helpers
    logic                       pop;
    int unsigned                free_slots;
    int unsigned                n_acc;
    int unsigned                n_drop;
    logic [NR_COMMIT_PORTS-1:0] accept;
    logic [ADDR_W-1:0]          wr_addr  [NR_COMMIT_PORTS];
    logic [2:0]                 port_cls [NR_COMMIT_PORTS];
    int unsigned                class_inc [NR_CLASSES];

    always_comb begin
        pop        = (count_q != '0) && trace_ready_i;
        // The slot freed by this cycle's pop is available to this cycle's pushes.
        free_slots = DEPTH - int'(count_q) + (pop ? 1 : 0);
        n_acc      = 0;
        n_drop     = 0;
        accept     = '0;
        for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
            port_cls[p] = classify(commit_instr_i[32*p +: 32]);
            wr_addr[p]  = ptr_add(wr_ptr_q, n_acc);
            if (commit_valid_i[p]) begin
                if (n_acc < free_slots) begin
                    accept[p] = 1'b1;
                    n_acc     = n_acc + 1;
                end else begin
                    n_drop = n_drop + 1;
                end
            end
        end
        // Class counts include dropped and flushed commits.
        for (int c = 0; c < NR_CLASSES; c++) begin
            class_inc[c] = 0;
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (commit_valid_i[p] && (port_cls[p] == 3'(c))) begin
                    class_inc[c] = class_inc[c] + 1;
                end
            end
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Pushes and pops of a flush cycle are discarded.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                if (accept[p]) begin
                    mem_q[wr_addr[p]] <= '{
                        instr: commit_instr_i[32*p +: 32],
                        pc:    commit_pc_i[XLEN*p +: XLEN],
                        cls:   port_cls[p],
                        port:  PORT_W'(p)
                    };
                end
            end
            if (pop) begin
                rd_ptr_q <= ptr_add(rd_ptr_q, 1);
            end
            wr_ptr_q <= ptr_add(wr_ptr_q, n_acc);
            count_q  <= count_q - COUNT_W'(pop) + COUNT_W'(n_acc);
        end
    end

    // Counters; clear wins over same-cycle increments.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            for (int c = 0; c < NR_CLASSES; c++) begin
                class_cnt_q[c] <= '0;
            end
        end else if (clear_cnt_i) begin
            drop_cnt_q <= '0;
            for (int c = 0; c < NR_CLASSES; c++) begin
                class_cnt_q[c] <= '0;
            end
        end else begin
            if (!flush_i) begin
                drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
            end
            for (int c = 0; c < NR_CLASSES; c++) begin
                class_cnt_q[c] <= sat_add(class_cnt_q[c], class_inc[c]);
            end
        end
    end

    // Outputs, all taken straight from registers
    assign trace_valid_o = (count_q != '0);
    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == COUNT_W'(DEPTH));
    assign trace_instr_o = mem_q[rd_ptr_q].instr;
    assign trace_pc_o    = mem_q[rd_ptr_q].pc;
    assign trace_class_o = mem_q[rd_ptr_q].cls;
    assign trace_port_o  = mem_q[rd_ptr_q].port;
    assign drop_cnt_o    = drop_cnt_q;

    for (genvar c = 0; c < NR_CLASSES; c++) begin : g_class_out
        assign class_cnt_o[CNT_WIDTH*c +: CNT_WIDTH] = class_cnt_q[c];
    end

endmodule
